// File: rtl/alu_pkg.sv
// Shared types and defaults for the streaming ALU reducer.
//   - ALU_DATA_WIDTH / ALU_NUM_WORD_WIDTH : default operand and word-count widths
//   - alu_op_e    : opcode encodings (5..7 are illegal)
//   - uint_t, uint_vld_t, alu_cmd_t, alu_res_t : bus payload types
//   - alu_state_e : reducer FSM states
//   - op_legal()  : true for the opcodes the reducer implements
package alu_pkg;

  localparam int unsigned ALU_DATA_WIDTH     = 8;
  localparam int unsigned ALU_NUM_WORD_WIDTH = 10;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_MUL  = 3'd2,
    ALU_DIV  = 3'd3,
    ALU_MEAN = 3'd4
  } alu_op_e;

  typedef logic [ALU_DATA_WIDTH-1:0] uint_t;

  typedef struct packed {
    logic  vld;
    uint_t data;
  } uint_vld_t;

  typedef struct packed {
    logic                          vld;
    logic [2:0]                    opcode;
    logic [ALU_NUM_WORD_WIDTH-1:0] num_words;
  } alu_cmd_t;

  typedef struct packed {
    logic  vld;
    uint_t data;
    logic  ovf;
    logic  dz;
    logic  err;
  } alu_res_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_RESP   = 2'd3
  } alu_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= ALU_MEAN);
  endfunction

endpackage

// File: rtl/alu_seq_div.sv
// Restoring sequential divider, one quotient bit per cycle.
// The first bit is resolved on the start cycle, so done pulses for one cycle
// DIVIDEND_WIDTH-1 cycles after start and quotient is valid from then on.
//   clk, rst  : clock, synchronous active-high reset (aborts a running divide)
//   start     : load dividend/divisor and begin
//   dividend  : DIVIDEND_WIDTH-bit unsigned numerator
//   divisor   : DIVISOR_WIDTH-bit unsigned denominator (must be nonzero)
//   done      : one-cycle pulse when quotient is final
//   quotient  : floored quotient
module alu_seq_div #(
  parameter int unsigned DIVIDEND_WIDTH = 8,
  parameter int unsigned DIVISOR_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient
);

  localparam int unsigned CNT_WIDTH = $clog2(DIVIDEND_WIDTH + 1);

  logic [DIVISOR_WIDTH-1:0]  rem_q, dvs_q, rem_src, dvs_src, rem_step;
  logic [DIVIDEND_WIDTH-1:0] quo_src, quo_step;
  logic [DIVISOR_WIDTH:0]    trial;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic                      run_q;

  // One restoring step; on start it operates on the fresh operands.
  // quotient doubles as the dividend shift register.
  always_comb begin
    rem_src = rem_q;
    quo_src = quotient;
    dvs_src = dvs_q;
    if (start) begin
      rem_src = '0;
      quo_src = dividend;
      dvs_src = divisor;
    end
    trial    = {rem_src, quo_src[DIVIDEND_WIDTH-1]};
    rem_step = trial[DIVISOR_WIDTH-1:0];
    quo_step = {quo_src[DIVIDEND_WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, dvs_src}) begin
      rem_step    = DIVISOR_WIDTH'(trial - {1'b0, dvs_src});
      quo_step[0] = 1'b1;
    end
  end

  // Iteration state; cnt_q holds the steps still to run.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      dvs_q    <= '0;
      quotient <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= rem_step;
        quotient <= quo_step;
        dvs_q    <= divisor;
        cnt_q    <= CNT_WIDTH'(DIVIDEND_WIDTH - 1);
        run_q    <= 1'b1;
      end else if (run_q) begin
        rem_q    <= rem_step;
        quotient <= quo_step;
        cnt_q    <= cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_stream_reducer.sv
// Streaming ALU reducer: takes one command (opcode, num_words), consumes
// num_words operands, reduces them per opcode and returns one result word.
// Optional macro ALU_STREAM_SAT_EN: saturate the result on overflow
// (ADD/MUL to all-ones, SUB clamps to 0 and stays there).
//   clk, rst                    : clock, synchronous active-high reset
//   cmd_vld/cmd_rdy             : command handshake (cmd_opcode, cmd_num_words)
//   din_vld/din_rdy/din_data    : operand stream
//   res_vld/res_rdy             : result handshake
//   res_data/res_ovf/res_dz/res_err : result word and status flags
//   busy                        : high outside IDLE
module alu_stream_reducer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = ALU_DATA_WIDTH,
  parameter int unsigned NUM_WORD_WIDTH = ALU_NUM_WORD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_vld,
  output logic                      cmd_rdy,
  input  logic [2:0]                cmd_opcode,
  input  logic [NUM_WORD_WIDTH-1:0] cmd_num_words,
  input  logic                      din_vld,
  output logic                      din_rdy,
  input  logic [DATA_WIDTH-1:0]     din_data,
  output logic                      res_vld,
  input  logic                      res_rdy,
  output logic [DATA_WIDTH-1:0]     res_data,
  output logic                      res_ovf,
  output logic                      res_dz,
  output logic                      res_err,
  output logic                      busy
);

  localparam int unsigned ACC_WIDTH  = DATA_WIDTH + NUM_WORD_WIDTH;
  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  alu_state_e                state, state_nxt;
  logic [2:0]                op_q, op_nxt;
  logic [NUM_WORD_WIDTH-1:0] nw_q, nw_nxt, left_q, left_nxt;
  logic [ACC_WIDTH-1:0]      acc_q, acc_nxt;
  logic                      ovf_q, ovf_nxt, dz_q, dz_nxt, err_q, err_nxt;
  logic                      pend_q, pend_nxt;
  logic                      res_load;
  logic [DATA_WIDTH-1:0]     res_data_nxt;
  logic                      res_ovf_nxt;
  logic [DATA_WIDTH:0]       sub_val;
  logic [PROD_WIDTH-1:0]     prod_val;
  logic                      sdiv_start, sdiv_done;
  logic [DATA_WIDTH-1:0]     sdiv_quo;
  logic                      mdiv_start, mdiv_done;
  logic [ACC_WIDTH-1:0]      mdiv_quo;

  // Word-by-word DIV on the low DATA_WIDTH bits of the accumulator.
  alu_seq_div #(
    .DIVIDEND_WIDTH(DATA_WIDTH),
    .DIVISOR_WIDTH (DATA_WIDTH)
  ) u_word_div (
    .clk     (clk),
    .rst     (rst),
    .start   (sdiv_start),
    .dividend(acc_q[DATA_WIDTH-1:0]),
    .divisor (din_data),
    .done    (sdiv_done),
    .quotient(sdiv_quo)
  );

  // MEAN: full-width sum divided by the word count; started with the final sum.
  alu_seq_div #(
    .DIVIDEND_WIDTH(ACC_WIDTH),
    .DIVISOR_WIDTH (NUM_WORD_WIDTH)
  ) u_mean_div (
    .clk     (clk),
    .rst     (rst),
    .start   (mdiv_start),
    .dividend(acc_nxt),
    .divisor (nw_q),
    .done    (mdiv_done),
    .quotient(mdiv_quo)
  );

  // Next-state, datapath update and result formatting.
  always_comb begin
    state_nxt    = state;
    op_nxt       = op_q;
    nw_nxt       = nw_q;
    left_nxt     = left_q;
    acc_nxt      = acc_q;
    ovf_nxt      = ovf_q;
    dz_nxt       = dz_q;
    err_nxt      = err_q;
    pend_nxt     = pend_q;
    res_load     = 1'b0;
    sdiv_start   = 1'b0;
    mdiv_start   = 1'b0;
    sub_val      = {1'b0, acc_q[DATA_WIDTH-1:0]} - {1'b0, din_data};
    prod_val     = PROD_WIDTH'(acc_q[DATA_WIDTH-1:0]) * PROD_WIDTH'(din_data);

    case (state)
      ST_IDLE: begin
        if (cmd_vld && cmd_rdy) begin
          op_nxt   = cmd_opcode;
          nw_nxt   = cmd_num_words;
          left_nxt = cmd_num_words;
          acc_nxt  = '0;
          ovf_nxt  = 1'b0;
          dz_nxt   = 1'b0;
          pend_nxt = 1'b0;
          err_nxt  = !op_legal(cmd_opcode) || (cmd_num_words == '0);
          if (cmd_num_words == '0) begin
            state_nxt = ST_RESP;
            res_load  = 1'b1;
          end else begin
            state_nxt = ST_ACCUM;
          end
        end
      end

      ST_ACCUM: begin
        if (pend_q) begin
          if (sdiv_done) begin
            acc_nxt  = ACC_WIDTH'(sdiv_quo);
            pend_nxt = 1'b0;
            if (left_q == '0) begin
              state_nxt = ST_RESP;
              res_load  = 1'b1;
            end
          end
        end else if (din_vld && din_rdy) begin
          left_nxt = left_q - NUM_WORD_WIDTH'(1);
          if (left_q == nw_q) begin
            // First word seeds the accumulator; illegal opcodes discard it.
            if (op_legal(op_q)) acc_nxt = ACC_WIDTH'(din_data);
          end else begin
            case (op_q)
              ALU_ADD, ALU_MEAN: acc_nxt = acc_q + ACC_WIDTH'(din_data);
              ALU_SUB: begin
                acc_nxt = ACC_WIDTH'(sub_val[DATA_WIDTH-1:0]);
                if (sub_val[DATA_WIDTH]) ovf_nxt = 1'b1;
`ifdef ALU_STREAM_SAT_EN
                // Clamp is sticky: once underflowed the result stays at 0.
                if (sub_val[DATA_WIDTH] || ovf_q) acc_nxt = '0;
`endif
              end
              ALU_MUL: begin
                acc_nxt = ACC_WIDTH'(prod_val[DATA_WIDTH-1:0]);
                if (|prod_val[PROD_WIDTH-1:DATA_WIDTH]) ovf_nxt = 1'b1;
              end
              ALU_DIV: begin
                // After a divide by zero the all-ones result is frozen.
                if (!dz_q) begin
                  if (din_data == '0) begin
                    acc_nxt = ACC_WIDTH'({DATA_WIDTH{1'b1}});
                    dz_nxt  = 1'b1;
                  end else begin
                    sdiv_start = 1'b1;
                    pend_nxt   = 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
          if (left_q == NUM_WORD_WIDTH'(1) && !pend_nxt) begin
            if (op_q == ALU_MEAN) begin
              mdiv_start = 1'b1;
              state_nxt  = ST_DIVIDE;
            end else begin
              state_nxt = ST_RESP;
              res_load  = 1'b1;
            end
          end
        end
      end

      ST_DIVIDE: begin
        if (mdiv_done) begin
          acc_nxt   = mdiv_quo;
          state_nxt = ST_RESP;
          res_load  = 1'b1;
        end
      end

      ST_RESP: begin
        if (res_vld && res_rdy) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase

    // ADD overflow is judged on the unwrapped sum.
    res_data_nxt = acc_nxt[DATA_WIDTH-1:0];
    res_ovf_nxt  = ovf_nxt;
    if (op_nxt == ALU_ADD) res_ovf_nxt = ovf_nxt | (|acc_nxt[ACC_WIDTH-1:DATA_WIDTH]);
    if (err_nxt) begin
      res_data_nxt = '0;
      res_ovf_nxt  = 1'b0;
    end
`ifdef ALU_STREAM_SAT_EN
    else if (res_ovf_nxt && (op_nxt == ALU_ADD || op_nxt == ALU_MUL)) begin
      res_data_nxt = '1;
    end
`endif
  end

  // State, datapath and registered outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      nw_q     <= '0;
      left_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      cmd_rdy  <= 1'b0;
      din_rdy  <= 1'b0;
      res_vld  <= 1'b0;
      res_data <= '0;
      res_ovf  <= 1'b0;
      res_dz   <= 1'b0;
      res_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      nw_q    <= nw_nxt;
      left_q  <= left_nxt;
      acc_q   <= acc_nxt;
      ovf_q   <= ovf_nxt;
      dz_q    <= dz_nxt;
      err_q   <= err_nxt;
      pend_q  <= pend_nxt;
      cmd_rdy <= (state_nxt == ST_IDLE);
      din_rdy <= (state_nxt == ST_ACCUM) && !pend_nxt;
      res_vld <= (state_nxt == ST_RESP);
      busy    <= (state_nxt != ST_IDLE);
      if (res_load) begin
        res_data <= res_data_nxt;
        res_ovf  <= res_ovf_nxt;
        res_dz   <= dz_nxt;
        res_err  <= err_nxt;
      end
    end
  end

endmodule
